// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequences the DIM feed FIFOs of the systolic array.
// IDLE routes host beats into per-row FIFOs until each holds DIM entries.
// RUN issues skewed shift enables and holds array_en for the full window.
// DONE pulses done and clears the load progress.
// Only enables and selects are produced here; no data passes through.
module systolic_feed_ctrl #(
    parameter  int unsigned DIM = 8,
    localparam int unsigned CW  = $clog2(3 * DIM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [$clog2(DIM)-1:0] in_row,
    output logic                   in_ready,
    input  logic                   start,
    input  logic                   clear,
    output logic [DIM-1:0]         fifo_en,
    output logic                   fifo_d_sel,
    output logic                   array_en,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned RW   = $clog2(DIM);
    localparam int unsigned CNTW = $clog2(DIM + 1);

    localparam logic [CW-1:0]   TLast = CW'(3 * DIM - 3);
    localparam logic [CNTW-1:0] Full  = CNTW'(DIM);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   t_q, t_d;
    logic [CNTW-1:0] count_q [DIM];
    logic [CNTW-1:0] count_d [DIM];

    logic row_ok;
    logic row_free;
    logic beat_ok;
    logic loaded;

    // Load status: every row full, and whether the addressed row can take a beat.
    always_comb begin
        loaded   = 1'b1;
        row_free = 1'b0;
        // Widen by one bit so out-of-range rows are caught for non power-of-two DIM.
        row_ok   = {1'b0, in_row} < (RW + 1)'(DIM);
        for (int i = 0; i < DIM; i++) begin
            if (count_q[i] != Full) begin
                loaded = 1'b0;
            end
            if (in_row == RW'(i) && count_q[i] != Full) begin
                row_free = 1'b1;
            end
        end
        // Gate with rst so outputs show reset values while reset is held.
        beat_ok = in_valid && row_ok && row_free && !rst;
    end

    // Next-state, counter updates and outputs.
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        count_d    = count_q;
        fifo_en    = '0;
        in_ready   = 1'b0;
        fifo_d_sel = 1'b1;
        array_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (clear) begin
                    for (int i = 0; i < DIM; i++) begin
                        count_d[i] = '0;
                    end
                end else begin
                    for (int i = 0; i < DIM; i++) begin
                        if (beat_ok && in_row == RW'(i)) begin
                            fifo_en[i] = 1'b1;
                            count_d[i] = count_q[i] + CNTW'(1);
                        end
                    end
                    err = !rst && ((in_valid && !beat_ok) || (start && !loaded));
                    if (start && loaded) begin
                        state_d = StRun;
                        t_d     = '0;
                    end
                end
            end

            StRun: begin
                busy       = 1'b1;
                array_en   = 1'b1;
                fifo_d_sel = 1'b0;
                // FIFO i shifts during t = i .. i+DIM-1, giving the diagonal skew.
                for (int i = 0; i < DIM; i++) begin
                    fifo_en[i] = (t_q >= CW'(i)) && (t_q <= CW'(i + DIM - 1));
                end
                if (t_q == TLast) begin
                    state_d = StDone;
                end else begin
                    t_d = t_q + CW'(1);
                end
            end

            StDone: begin
                done = 1'b1;
                t_d  = '0;
                for (int i = 0; i < DIM; i++) begin
                    count_d[i] = '0;
                end
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, run counter and per-row fill counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            t_q     <= '0;
            for (int i = 0; i < DIM; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            count_q <= count_d;
        end
    end

    // Run counter must never pass the last run cycle.
    t_range_a: assert property (@(posedge clk) disable iff (rst) t_q <= TLast);

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: directed bench for systolic_feed_ctrl with DIM = 4.
// A cycle-level model derives every output from the load/run rules; a compare
// process checks it each cycle, and literal checks pin key points of the model.
module tb_systolic_feed_ctrl;

    localparam int unsigned DIM    = 4;
    localparam int          RunLen = 3 * DIM - 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_row = 2'd0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       in_ready;
    logic [3:0] fifo_en;
    logic       fifo_d_sel;
    logic       array_en;
    logic       busy;
    logic       done;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    systolic_feed_ctrl #(.DIM(DIM)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_row     (in_row),
        .in_ready   (in_ready),
        .start      (start),
        .clear      (clear),
        .fifo_en    (fifo_en),
        .fifo_d_sel (fifo_d_sel),
        .array_en   (array_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // A run is remembered only by the cycle it began; phase follows from elapsed cycles.
    int cnt [DIM];
    int cyc       = 0;
    int run_start = -1000;

    function automatic bit model_loaded();
        for (int i = 0; i < DIM; i++) if (cnt[i] != DIM) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_legal();
        return in_valid && (int'(in_row) < DIM) && (cnt[in_row] < DIM);
    endfunction

    // Packed as {fifo_en, in_ready, fifo_d_sel, array_en, busy, done, err}.
    function automatic logic [9:0] model_out();
        int         k;
        logic [3:0] en;
        logic       e;
        k  = cyc - run_start;
        en = '0;
        if (rst) return {4'b0000, 6'b110000};
        if (k >= 0 && k < RunLen) begin
            for (int i = 0; i < DIM; i++) if (i <= k && k <= i + DIM - 1) en[i] = 1'b1;
            return {en, 6'b001100};
        end
        if (k == RunLen) return {4'b0000, 6'b010010};
        if (clear) return {4'b0000, 6'b110000};
        if (model_legal()) en[in_row] = 1'b1;
        e = (in_valid && !model_legal()) || (start && !model_loaded());
        return {en, 5'b11000, e};
    endfunction

    task automatic model_step();
        int k;
        bit legal;
        bit ld;
        k     = cyc - run_start;
        legal = model_legal();
        ld    = model_loaded();
        if (rst) begin
            for (int i = 0; i < DIM; i++) cnt[i] = 0;
            run_start = -1000;
        end else if (k == RunLen) begin
            for (int i = 0; i < DIM; i++) cnt[i] = 0;
        end else if (!(k >= 0 && k < RunLen)) begin
            if (clear) begin
                for (int i = 0; i < DIM; i++) cnt[i] = 0;
            end else begin
                if (legal) cnt[in_row] = cnt[in_row] + 1;
                if (start && ld) run_start = cyc + 1;
            end
        end
        cyc++;
    endtask

    // Compare process: mid-low-phase check, model advance on each rising edge.
    initial begin
        for (int i = 0; i < DIM; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            #2;
            check("outputs", {22'd0, fifo_en, in_ready, fifo_d_sel, array_en, busy, done, err},
                  {22'd0, model_out()});
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [1:0] row, input logic st, input logic clr);
        @(negedge clk);
        in_valid = v;
        in_row   = row;
        start    = st;
        clear    = clr;
    endtask

    task automatic load_beats(input int n);
        for (int b = 0; b < n; b++) begin
            drive(1'b1, 2'(b % DIM), 1'b0, 1'b0);
            #2;
            check("load_en", 32'(fifo_en), 32'(4'b0001 << (b % DIM)));
            check("load_err", 32'(err), 32'd0);
        end
    endtask

    logic [3:0] skew [RunLen];

    initial begin
        skew = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

        // Reset asserted mid-cycle with a beat and start presented.
        in_valid = 1'b1;
        start    = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_dsel", 32'(fifo_d_sel), 32'd1);
        check("rst_others", 32'({fifo_en, array_en, busy, done, err}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;

        // Full load, rows 0..3 repeating.
        load_beats(16);

        // Overfill row 2.
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        #2;
        check("overfill_err", 32'(err), 32'd1);
        check("overfill_en", 32'(fifo_en), 32'd0);

        // Run with skew table.
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        #2;
        check("start_ok_err", 32'(err), 32'd0);
        for (int k = 0; k < RunLen; k++) begin
            drive(1'b0, 2'd0, 1'b0, 1'b0);
            #2;
            check("skew_en", 32'(fifo_en), 32'(skew[k]));
            check("skew_array_en", 32'(array_en), 32'd1);
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        #2;
        check("done_pulse", 32'({done, fifo_en, array_en}), 32'b1_0000_0);
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        #2;
        check("post_done", 32'({in_ready, done}), 32'b10);

        // Start with row 3 one short.
        load_beats(15);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        #2;
        check("bad_start_err", 32'(err), 32'd1);
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        #2;
        check("bad_start_idle", 32'({busy, in_ready}), 32'b01);
        drive(1'b1, 2'd3, 1'b0, 1'b0);

        // Clear priority over start and beat.
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        load_beats(6);
        drive(1'b1, 2'd1, 1'b1, 1'b1);
        #2;
        check("clear_en", 32'({fifo_en, err}), 32'd0);
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        #2;
        check("clear_no_run", 32'(busy), 32'd0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        #2;
        check("clear_start_err", 32'(err), 32'd1);

        // Reset in the middle of a run; inputs during RUN are ignored.
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        load_beats(16);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            drive(k == 2, 2'd0, k == 2, k == 3);
        end
        #3 rst = 1'b1;
        #1;
        check("midrun_rst", 32'({busy, array_en, fifo_en, in_ready}), 32'b0_0_0000_1);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        for (int k = 0; k < 12; k++) drive(1'b0, 2'd0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        #2;
        check("reload_needed", 32'(err), 32'd1);
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0);

        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencer for the bank of `DIM` delay FIFOs that feed the systolic multiply array. It controls two phases:

- **Load:** routes host-supplied row beats into the selected FIFO until every FIFO holds `DIM` entries.
- **Run:** on `start`, it issues skewed shift enables so that FIFO *i* begins emitting *i* cycles after FIFO 0. It holds the array enable for the full propagation window and then pulses `done`.

The block sits between the MMIO/CSR decode and the FIFO/array datapath. It never touches data, only enables and selects.

## Interface
Parameters:
- `DIM`, default 8: number of FIFOs, FIFO depth and array dimension; legal range 2..64.
- `CW`, default `$clog2(3*DIM)`: width of the run cycle counter. Derived; not overridden.

Ports:
- `clk` input 1: single clock, all logic on its rising edge.
- `rst` input 1: asynchronous active-high reset.
- `in_valid` input 1: a load beat is present.
- `in_row` input `$clog2(DIM)`: target FIFO index of the beat.
- `in_ready` output 1: the block accepts beats; high only in IDLE.
- `start` input 1: single-cycle request to begin the run phase.
- `clear` input 1: discards load progress; honoured in IDLE only.
- `fifo_en` output `DIM`: per-FIFO enable, one bit per FIFO.
- `fifo_d_sel` output 1: FIFO write-data select. 1 selects the host beat data; 0 selects zero fill during run.
- `array_en` output 1: systolic array enable.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when a run completes.
- `err` output 1: one-cycle pulse when an illegal beat or start is rejected.

## Operation
- **States:** IDLE, RUN, DONE. Reset enters IDLE.
- **Reset values:**
  - All outputs 0, except `in_ready` = 1 and `fifo_d_sel` = 1.
  - Per-row fill counters (each `$clog2(DIM+1)` bits) = 0.
  - Run counter `t` = 0.
- **IDLE, accepted beat:** when `in_valid` is high, `in_row` < `DIM` and `count[in_row]` < `DIM`:
  - `fifo_en[in_row]` = 1 for that cycle, with `fifo_d_sel` = 1.
  - `count[in_row]` increments.
- **IDLE, rejected beat:** when `in_row` ≥ `DIM` or the target row is already full:
  - The beat is dropped and no `fifo_en` bit is asserted.
  - `err` pulses in the same cycle.
- **`loaded`:** true when every `count[i]` = `DIM`.
- **`start` in IDLE:**
  - If `loaded`: go to RUN with `t` = 0. Any beat presented in the same cycle is still accepted if it is legal.
  - If not `loaded`: `start` is ignored and `err` pulses.
- **`clear` in IDLE:**
  - All counters go to 0 and no beat is accepted that cycle.
  - `clear` takes priority over `start` and over `in_valid`.
- **RUN:**
  - `in_ready` = 0, `busy` = 1, `array_en` = 1, `fifo_d_sel` = 0.
  - `fifo_en[i]` = 1 exactly when `i` ≤ `t` ≤ `i+DIM-1`.
  - `t` increments every cycle.
  - When `t` = `3*DIM-3`, the next state is DONE.
  - `in_valid`, `start` and `clear` are ignored, with no `err` pulse.
- **DONE:** lasts one cycle.
  - `done` = 1 and all enables are 0.
  - All counters are reset to 0 and `t` = 0.
  - Next state is IDLE.
- **`rst` at any point**, including mid-RUN: immediate return to the reset values. Partial load progress is lost.

## Timing
- Load beat to FIFO write is combinational: `fifo_en` is asserted in the same cycle as the accepted `in_valid`.
- `start` sampled at edge N → RUN from cycle N+1. The first `fifo_en[0]` appears in that cycle (`t` = 0).
- RUN length is exactly `3*DIM-2` cycles. `done` is asserted in the cycle after the last RUN cycle.
- A new load is possible on the cycle after `done`; `in_ready` is 1 in that cycle.
- There are no back-to-back runs without a full reload.
- The width of `t` must hold `3*DIM-3` without wrap. An assertion checks that `t` never exceeds that value.

## Test plan
The scenarios below use `DIM` = 4.

- **Reset:** assert `rst` mid-cycle → all outputs hold their reset values asynchronously; `in_ready` = 1.
- **Full load:** 16 beats, rows 0,1,2,3 repeating → each beat drives a one-hot `fifo_en` matching its row; no `err`; `loaded` is set after beat 16.
- **Overfill and bad start:**
  - A 5th beat to row 2 → `err` pulse and `fifo_en` = 0000.
  - `start` with row 3 holding 3 entries → `err` pulse and the block stays in IDLE.
- **Run skew:** after a full load, pulse `start` → `fifo_en` by `t`:
  - `t` = 0: 0001
  - `t` = 1: 0011
  - `t` = 3: 1111
  - `t` = 4: 1110
  - `t` = 6: 1000
  - `t` = 7 to 9: 0000
  - `array_en` = 1 for 10 cycles, then `done` pulses once and `in_ready` returns to 1.
- **`clear` priority:**
  - 6 beats loaded, then `clear` together with `start` and `in_valid` → counters go to 0, no `fifo_en`, no RUN.
  - A following `start` → `err` pulse.
- **Reset mid-RUN:** at `t` = 5, assert `rst` → `busy`, `array_en` and `fifo_en` drop immediately; `done` never pulses; a reload is required before the next run.
